// File: rtl/button_scan_ctrl.sv
// Debounced scanner for N_KEYS active-low push buttons with press/release/long-press pulses.
// Latency: 2 sync clocks + SAMPLES ticks + scan slot; no backpressure, every pulse is one clock wide.
module button_scan_ctrl #(
   parameter int N_KEYS     = 4,
   parameter int CLK_DIV    = 50000,
   parameter int SAMPLES    = 3,
   parameter int LONG_TICKS = 1000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] keys_raw,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic              busy,
   output logic              overrun
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
   localparam int LONG_W = $clog2(LONG_TICKS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_KEYS - 1);
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [N_KEYS-1:0] sync_a;
   logic [N_KEYS-1:0] sync_b;
   logic [N_KEYS-1:0] key_lvl;

   logic [DIV_W-1:0]  div_cnt;
   logic              tick;

   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;

   logic [SAMPLES-1:0] hist     [N_KEYS];
   logic [LONG_W-1:0]  long_cnt [N_KEYS];

   logic [SAMPLES-1:0] cur_hist;
   logic [SAMPLES-1:0] new_hist;
   logic [LONG_W-1:0]  cur_long;
   logic [LONG_W-1:0]  long_nxt;
   logic               cur_state;
   logic               accept_press;
   logic               accept_release;
   logic               long_fire;

   // Raw levels idle high, so the synchronizer resets to the unpressed level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '1;
         sync_b <= '1;
      end else begin
         sync_a <= keys_raw;
         sync_b <= sync_a;
      end
   end

   assign key_lvl = ~sync_b;

   // tick is high for the single clock in which the divider sits at 0 after wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         tick    <= (div_cnt == DIV_LAST);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (tick) begin
               state_nxt = SCAN;
               idx_nxt   = '0;
            end
         end
         SCAN: begin
            if (idx == IDX_LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // A tick landing outside IDLE is dropped; the flag records that CLK_DIV is too short.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (tick && (state != IDLE)) begin
         overrun <= 1'b1;
      end
   end

   always_comb begin
      cur_hist       = hist[idx];
      cur_long       = long_cnt[idx];
      cur_state      = key_state[idx];
      new_hist       = {cur_hist[SAMPLES-2:0], key_lvl[idx]};
      accept_press   = (state == SCAN) && (&new_hist) && !cur_state;
      accept_release = (state == SCAN) && !(|new_hist) && cur_state;
      long_nxt       = cur_long;
      long_fire      = 1'b0;
      if (accept_press) begin
         // The accepting scan already counts as the first held tick.
         long_nxt  = LONG_W'(1);
         long_fire = (LONG_TICKS == 1);
      end else if (accept_release) begin
         long_nxt = '0;
      end else if (cur_state && (cur_long != LONG_MAX)) begin
         long_nxt  = cur_long + 1'b1;
         long_fire = ((cur_long + 1'b1) == LONG_MAX);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_KEYS; i++) begin
            hist[i]     <= '0;
            long_cnt[i] <= '0;
         end
         key_state   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_long    <= '0;
      end else begin
         key_press   <= '0;
         key_release <= '0;
         key_long    <= '0;
         if (state == SCAN) begin
            hist[idx]     <= new_hist;
            long_cnt[idx] <= long_nxt;
            key_long[idx] <= long_fire;
            if (accept_press) begin
               key_state[idx] <= 1'b1;
               key_press[idx] <= 1'b1;
            end
            if (accept_release) begin
               key_state[idx]   <= 1'b0;
               key_release[idx] <= 1'b1;
            end
         end
      end
   end

endmodule
